// File: rtl/max7219_rx_pkg.sv
// Shared definitions for the MAX7219 serial stream receiver.
// Register addresses and per-device word field positions.
package max7219_rx_pkg;

  localparam logic [3:0] ADDR_NOOP         = 4'h0;
  localparam logic [3:0] ADDR_DIGIT0       = 4'h1;
  localparam logic [3:0] ADDR_DIGIT7       = 4'h8;
  localparam logic [3:0] ADDR_DECODE       = 4'h9;
  localparam logic [3:0] ADDR_INTENSITY    = 4'hA;
  localparam logic [3:0] ADDR_SCAN_LIMIT   = 4'hB;
  localparam logic [3:0] ADDR_SHUTDOWN     = 4'hC;
  localparam logic [3:0] ADDR_DISPLAY_TEST = 4'hF;

  localparam int WORD_W   = 16;
  localparam int ADDR_LSB = 8;
  localparam int DATA_LSB = 0;

  localparam logic [7:0] CNT_MAX = 8'hFF;

  function automatic logic is_digit(input logic [3:0] a);
    return (a >= ADDR_DIGIT0) && (a <= ADDR_DIGIT7);
  endfunction

endpackage

// File: rtl/max7219_rx_sync.sv
// Multi-flop synchronizer with rise/fall detect on the synced level.
// Ports: clk, rst, d (async pin) -> q (synced), rise, fall (1-cycle).
module max7219_rx_sync #(
  parameter int   STAGES = 2,
  parameter logic INIT   = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] ff;
  logic              prev;

  // Reset loads the idle level so no edge is seen on release.
  always_ff @(posedge clk) begin
    if (rst) begin
      ff   <= {STAGES{INIT}};
      prev <= INIT;
    end else begin
      ff   <= {ff[STAGES-2:0], d};
      prev <= ff[STAGES-1];
    end
  end

  assign q    = ff[STAGES-1];
  assign rise = q & ~prev;
  assign fall = ~q & prev;

endmodule

// File: rtl/max7219_rx.sv
// MAX7219 daisy-chain receiver: shift, latch, decode, framebuffer read.
// Ports: m_cs/m_sclk/m_din in, m_dout cascade, rd_* read port, ctrl + strobes.
module max7219_rx
  import max7219_rx_pkg::*;
#(
  parameter int NUM_DEVICES = 4,
  parameter int SYNC_STAGES = 2,
  localparam int DEV_W = (NUM_DEVICES > 1) ? $clog2(NUM_DEVICES) : 1,
  localparam int SR_W  = WORD_W * NUM_DEVICES
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     m_cs,
  input  logic                     m_sclk,
  input  logic                     m_din,
  output logic                     m_dout,
  input  logic [DEV_W-1:0]         rd_dev,
  input  logic [2:0]               rd_row,
  output logic [7:0]               rd_data,
  output logic [NUM_DEVICES-1:0]   shutdown_n,
  output logic [4*NUM_DEVICES-1:0] intensity,
  output logic [3*NUM_DEVICES-1:0] scan_limit,
  output logic [8*NUM_DEVICES-1:0] decode_mode,
  output logic [NUM_DEVICES-1:0]   disp_test,
  output logic                     frame_strobe,
  output logic                     frame_err
);

  logic cs_q, cs_rise, cs_fall;
  logic sclk_q_unused, sclk_rise, sclk_fall_unused;
  logic din_q, din_rise_unused, din_fall_unused;

  max7219_rx_sync #(.STAGES(SYNC_STAGES), .INIT(1'b1)) u_cs (
    .clk  (clk),
    .rst  (rst),
    .d    (m_cs),
    .q    (cs_q),
    .rise (cs_rise),
    .fall (cs_fall)
  );

  max7219_rx_sync #(.STAGES(SYNC_STAGES), .INIT(1'b0)) u_sclk (
    .clk  (clk),
    .rst  (rst),
    .d    (m_sclk),
    .q    (sclk_q_unused),
    .rise (sclk_rise),
    .fall (sclk_fall_unused)
  );

  max7219_rx_sync #(.STAGES(SYNC_STAGES), .INIT(1'b0)) u_din (
    .clk  (clk),
    .rst  (rst),
    .d    (m_din),
    .q    (din_q),
    .rise (din_rise_unused),
    .fall (din_fall_unused)
  );

  logic [SR_W-1:0] shreg, shreg_nxt;
  logic [7:0]      cnt, cnt_nxt;
  logic            shift_en;
  logic            bad_cnt;

  logic [3:0] w_addr [NUM_DEVICES];
  logic [7:0] w_data [NUM_DEVICES];
  logic [7:0] digit  [NUM_DEVICES][8];

  // cs_rise means cs was low on the previous sample, so a
  // coincident sclk rise still belongs to this frame.
  always_comb begin
    shift_en  = sclk_rise & (~cs_q | cs_rise);
    shreg_nxt = shreg;
    cnt_nxt   = cnt;
    if (shift_en) begin
      shreg_nxt = {shreg[SR_W-2:0], din_q};
      if (cnt != CNT_MAX) cnt_nxt = cnt + 8'd1;
    end
    if (cs_fall) cnt_nxt = '0;
    bad_cnt = (cnt_nxt == 8'd0) | (cnt_nxt[3:0] != 4'd0);
  end

  // Latch decodes from shreg_nxt so the final bit is included.
  always_comb begin
    for (int k = 0; k < NUM_DEVICES; k++) begin
      w_addr[k] = shreg_nxt[WORD_W*k+ADDR_LSB +: 4];
      w_data[k] = shreg_nxt[WORD_W*k+DATA_LSB +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shreg        <= '0;
      cnt          <= '0;
      m_dout       <= 1'b0;
      frame_strobe <= 1'b0;
      frame_err    <= 1'b0;
    end else begin
      shreg        <= shreg_nxt;
      cnt          <= cnt_nxt;
      m_dout       <= shreg_nxt[SR_W-1];
      frame_strobe <= cs_rise;
      frame_err    <= cs_rise & bad_cnt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < NUM_DEVICES; k++) begin
        for (int r = 0; r < 8; r++) digit[k][r] <= '0;
      end
      shutdown_n  <= '0;
      intensity   <= '0;
      scan_limit  <= '0;
      decode_mode <= '0;
      disp_test   <= '0;
    end else if (cs_rise) begin
      for (int k = 0; k < NUM_DEVICES; k++) begin
        unique case (1'b1)
          (w_addr[k] == ADDR_NOOP): ;
          is_digit(w_addr[k]):
            digit[k][3'(w_addr[k] - ADDR_DIGIT0)] <= w_data[k];
          (w_addr[k] == ADDR_DECODE):
            decode_mode[8*k +: 8] <= w_data[k];
          (w_addr[k] == ADDR_INTENSITY):
            intensity[4*k +: 4] <= w_data[k][3:0];
          (w_addr[k] == ADDR_SCAN_LIMIT):
            scan_limit[3*k +: 3] <= w_data[k][2:0];
          (w_addr[k] == ADDR_SHUTDOWN):
            shutdown_n[k] <= w_data[k][0];
          (w_addr[k] == ADDR_DISPLAY_TEST):
            disp_test[k] <= w_data[k][0];
          default: ;
        endcase
      end
    end
  end

  // Reads the pre-latch contents in a latch cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data <= '0;
    end else if (int'(rd_dev) < NUM_DEVICES) begin
      rd_data <= digit[rd_dev][rd_row];
    end else begin
      rd_data <= '0;
    end
  end

endmodule

// File: tb/tb_max7219_rx.sv
// Scoreboard bench for max7219_rx: queued expectations, decoupled monitor.
// Drives serial frames on m_cs/m_sclk/m_din and reads back registers.
module tb_max7219_rx;

  localparam int N = 4;

  localparam int K_DIG = 0;
  localparam int K_SHD = 1;
  localparam int K_INT = 2;
  localparam int K_SCN = 3;
  localparam int K_DEC = 4;
  localparam int K_TST = 5;
  localparam int K_OUT = 6;

  typedef struct {
    string      name;
    int         kind;
    int         dev;
    logic [7:0] val;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         m_cs, m_sclk, m_din, m_dout;
  logic [1:0]   rd_dev;
  logic [2:0]   rd_row;
  logic [7:0]   rd_data;
  logic [N-1:0] shutdown_n, disp_test;
  logic [4*N-1:0] intensity;
  logic [3*N-1:0] scan_limit;
  logic [8*N-1:0] decode_mode;
  logic         frame_strobe, frame_err;

  logic rd_req = 1'b0;
  logic rd_pend = 1'b0;

  exp_t rq[$];
  logic sq[$];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  max7219_rx #(.NUM_DEVICES(N), .SYNC_STAGES(2)) dut (
    .clk          (clk),
    .rst          (rst),
    .m_cs         (m_cs),
    .m_sclk       (m_sclk),
    .m_din        (m_din),
    .m_dout       (m_dout),
    .rd_dev       (rd_dev),
    .rd_row       (rd_row),
    .rd_data      (rd_data),
    .shutdown_n   (shutdown_n),
    .intensity    (intensity),
    .scan_limit   (scan_limit),
    .decode_mode  (decode_mode),
    .disp_test    (disp_test),
    .frame_strobe (frame_strobe),
    .frame_err    (frame_err)
  );

  always @(posedge clk) rd_pend <= rd_req;

  always @(negedge clk) begin
    exp_t       e;
    logic [7:0] act;
    logic       er;
    if (frame_err && !frame_strobe) begin
      checks++;
      errors++;
      $display("FAIL err_no_strobe: frame_err=1 frame_strobe=0");
    end
    if (frame_strobe) begin
      checks++;
      if (sq.size() == 0) begin
        errors++;
        $display("FAIL unexpected_strobe: got strobe, none expected");
      end else begin
        er = sq.pop_front();
        if (frame_err !== er) begin
          errors++;
          $display("FAIL frame_err: got %b want %b", frame_err, er);
        end
      end
    end
    if (rd_pend) begin
      checks++;
      if (rq.size() == 0) begin
        errors++;
        $display("FAIL scoreboard_underflow: read with empty queue");
      end else begin
        e = rq.pop_front();
        case (e.kind)
          K_DIG:   act = rd_data;
          K_SHD:   act = {7'd0, shutdown_n[e.dev]};
          K_INT:   act = {4'd0, intensity[4*e.dev +: 4]};
          K_SCN:   act = {5'd0, scan_limit[3*e.dev +: 3]};
          K_DEC:   act = decode_mode[8*e.dev +: 8];
          K_TST:   act = {7'd0, disp_test[e.dev]};
          default: act = {7'd0, m_dout};
        endcase
        if (act !== e.val) begin
          errors++;
          $display("FAIL %s: got %h want %h", e.name, act, e.val);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_reg(input string name, input int kind,
                            input int dev, input int row,
                            input logic [7:0] val);
    exp_t e;
    e.name = name;
    e.kind = kind;
    e.dev  = dev;
    e.val  = val;
    rd_dev = 2'(dev);
    rd_row = 3'(row);
    rd_req = 1'b1;
    rq.push_back(e);
    tick(1);
    rd_req = 1'b0;
  endtask

  task automatic send_bits(input logic [63:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      m_din = v[i];
      tick(4);
      m_sclk = 1'b1;
      tick(4);
      m_sclk = 1'b0;
      tick(4);
    end
  endtask

  task automatic frame(input logic [63:0] v, input int n,
                       input logic err);
    m_cs = 1'b0;
    tick(4);
    send_bits(v, n);
    sq.push_back(err);
    m_cs = 1'b1;
    tick(10);
  endtask

  initial begin
    int guard;
    rst    = 1'b1;
    m_cs   = 1'b1;
    m_sclk = 1'b0;
    m_din  = 1'b0;
    rd_dev = '0;
    rd_row = '0;
    tick(5);
    rst = 1'b0;
    tick(5);

    for (int d = 0; d < N; d++) begin
      for (int r = 0; r < 8; r++) expect_reg("rst_digit", K_DIG, d, r, 8'h00);
      expect_reg("rst_shutdown", K_SHD, d, 0, 8'h00);
      expect_reg("rst_intensity", K_INT, d, 0, 8'h00);
    end
    expect_reg("rst_dout", K_OUT, 0, 0, 8'h00);

    frame(64'h01A5, 16, 1'b0);
    expect_reg("f1_dev0_row0", K_DIG, 0, 0, 8'hA5);
    expect_reg("f1_dev1_row0", K_DIG, 1, 0, 8'h00);
    expect_reg("f1_dev3_row0", K_DIG, 3, 0, 8'h00);
    expect_reg("f1_dout", K_OUT, 0, 0, 8'h00);

    frame(64'h033C_0C01_0A07_0881, 64, 1'b0);
    expect_reg("f2_dev3_row2", K_DIG, 3, 2, 8'h3C);
    expect_reg("f2_dev2_shdn", K_SHD, 2, 0, 8'h01);
    expect_reg("f2_dev1_int", K_INT, 1, 0, 8'h07);
    expect_reg("f2_dev0_row7", K_DIG, 0, 7, 8'h81);
    expect_reg("f2_dev0_row0", K_DIG, 0, 0, 8'hA5);
    expect_reg("f2_dout", K_OUT, 0, 0, 8'h00);

    // sclk noise with cs high must not shift the chain
    m_din = 1'b1;
    for (int i = 0; i < 16; i++) begin
      m_sclk = 1'b1;
      tick(4);
      m_sclk = 1'b0;
      tick(4);
    end
    m_din = 1'b0;
    expect_reg("noise_dout", K_OUT, 0, 0, 8'h00);
    frame(64'h0155, 16, 1'b0);
    expect_reg("f3_dev0_row0", K_DIG, 0, 0, 8'h55);
    expect_reg("f3_dev1_row7", K_DIG, 1, 7, 8'h81);
    expect_reg("f3_dev2_int", K_INT, 2, 0, 8'h07);
    expect_reg("f3_dev3_shdn", K_SHD, 3, 0, 8'h01);
    expect_reg("f3_dev1_test", K_TST, 1, 0, 8'h00);

    frame(64'h7FFF, 15, 1'b1);
    frame(64'h0C01, 16, 1'b0);
    expect_reg("f5_dev0_shdn", K_SHD, 0, 0, 8'h01);

    frame(64'h09FF_0B05_0F01, 48, 1'b0);
    expect_reg("f6_dev2_dec", K_DEC, 2, 0, 8'hFF);
    expect_reg("f6_dev1_scan", K_SCN, 1, 0, 8'h05);
    expect_reg("f6_dev0_test", K_TST, 0, 0, 8'h01);

    // reset in the middle of a frame
    m_cs = 1'b0;
    tick(4);
    send_bits(64'hFF, 8);
    rst = 1'b1;
    tick(2);
    m_cs   = 1'b1;
    m_sclk = 1'b0;
    tick(2);
    rst = 1'b0;
    tick(4);
    expect_reg("mrst_dev0_row0", K_DIG, 0, 0, 8'h00);
    expect_reg("mrst_dev0_shdn", K_SHD, 0, 0, 8'h00);
    expect_reg("mrst_dev1_scan", K_SCN, 1, 0, 8'h00);
    expect_reg("mrst_dout", K_OUT, 0, 0, 8'h00);
    frame(64'h0255, 16, 1'b0);
    expect_reg("f7_dev0_row1", K_DIG, 0, 1, 8'h55);
    expect_reg("f7_dev0_row0", K_DIG, 0, 0, 8'h00);

    guard = 0;
    while ((rq.size() != 0 || sq.size() != 0) && guard < 100) begin
      tick(1);
      guard++;
    end
    if (rq.size() != 0 || sq.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: got %0d reads %0d strobes pending want 0",
               rq.size(), sq.size());
    end
    tick(2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
